mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter_pkg.sv | 26 ++
 rtl/mux4_1.sv | 27 ++
 rtl/rr_pick4.sv | 34 +++
 rtl/mux4_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_pkg
//   Shared definitions for the 4-way round-robin arbitrated mux:
//     - FSM state encoding (IDLE=0, GRANT=1)
//     - requester count and mux-select width
//     - index -> one-hot grant decode helper
// ---------------------------------------------------------------------------
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Decode a requester index into its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// ---------------------------------------------------------------------------
// mux4_1
//   Plain 4:1 single-bit multiplexer.
//   Ports:
//     S       - 2-bit select
//     A0..A3  - data inputs
//     Y       - selected data (A[S])
// ---------------------------------------------------------------------------
module mux4_1 (
    input  logic [1:0] S,
    input  logic       A0,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    output logic       Y
);

    always_comb begin
        case (S)
            2'd0:    Y = A0;
            2'd1:    Y = A1;
            2'd2:    Y = A2;
            default: Y = A3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
//   Combinational round-robin search over 4 request lines.
//   Ports:
//     req   - request vector, bit i = requester i
//     start - first index examined; order is start, start+1, .. mod 4
//     idx   - first set request found in that order (start when none)
//     any   - at least one request is set
// ---------------------------------------------------------------------------
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest offset back to offset 0 so the closest set
    // request to 'start' is the last one written and therefore wins.
    // The SEL_W-bit add wraps naturally, giving the mod-4 order.
    always_comb begin
        idx  = start;
        cand = start;
        any  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter owning a shared 4:1 data mux. One requester at a
//   time is granted; the grant is held while its request stays high, for at
//   most MAX_HOLD consecutive cycles when others are waiting. A sole
//   requester keeps the grant indefinitely.
//
//   Parameters:
//     MAX_HOLD  - max consecutive grant cycles before forced rotation (2..15)
//   Ports:
//     clk       - clock, rising edge
//     rst       - synchronous active-high reset
//     req[3:0]  - request from requester i on bit i
//     A0..A3    - data from requesters 0..3
//     gnt[3:0]  - registered one-hot grant, zero when idle
//     gnt_valid - a grant is held (|gnt)
//     S[1:0]    - registered mux select = index of granted requester
//     Y         - A[S] while gnt_valid, else 0
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               A0,
    input  logic               A1,
    input  logic               A2,
    input  logic               A3,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [SEL_W-1:0]   S,
    output logic               Y
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [SEL_W-1:0]   s_q,     s_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;

    logic [NUM_REQ-1:0] pick_req;
    logic [SEL_W-1:0]   pick_start;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic [SEL_W-1:0]   s_next_idx;
    logic               mux_y;

    assign s_next_idx = s_q + SEL_W'(1);

    // One picker serves both states. From IDLE the search starts at ptr over
    // all requests. In GRANT it starts just past the owner and the owner is
    // masked out, so a hand-off or forced rotation never re-picks it.
    assign pick_req   = (state_q == ST_IDLE) ? req   : (req & ~gnt_q);
    assign pick_start = (state_q == ST_IDLE) ? ptr_q : s_next_idx;

    rr_pick4 u_pick (
        .req   (pick_req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state / next-grant logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                // S keeps its last value while idle; only gnt is cleared.
                gnt_d = '0;
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = idx_to_onehot(pick_idx);
                    s_d     = pick_idx;
                    hold_d  = '0;
                end
            end

            ST_GRANT: begin
                if (!req[s_q]) begin
                    // Owner released: hand straight to the next waiter with
                    // no idle bubble, or drop back to IDLE.
                    ptr_d  = s_next_idx;
                    hold_d = '0;
                    if (pick_any) begin
                        gnt_d = idx_to_onehot(pick_idx);
                        s_d   = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else if (pick_any) begin
                    // Hold budget spent and someone else waits: rotate.
                    ptr_d  = s_next_idx;
                    gnt_d  = idx_to_onehot(pick_idx);
                    s_d    = pick_idx;
                    hold_d = '0;
                end
                // Otherwise: sole requester, keep grant with hold saturated.
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Shared data path: select from registered S, gated by grant.
    mux4_1 u_mux (
        .S  (s_q),
        .A0 (A0),
        .A1 (A1),
        .A2 (A2),
        .A3 (A3),
        .Y  (mux_y)
    );

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign S         = s_q;
    assign Y         = gnt_valid & mux_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed scoreboard bench. Each stimulus cycle drives rst/req/A at the
//   falling edge and queues the hand-computed grant and select expected
//   after the following rising edge. A free-running monitor samples shortly
//   after every rising edge, pops the queue and compares gnt, S, gnt_valid
//   and Y; it also checks gnt is never multi-hot.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] s;
        string      nm;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a_vec;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] S;
    logic       Y;

    exp_t q[$];
    int   checks;
    int   errors;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .A0        (a_vec[0]),
        .A1        (a_vec[1]),
        .A2        (a_vec[2]),
        .A3        (a_vec[3]),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .S         (S),
        .Y         (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s: got %b want %b", nm, fld, got, want);
        end
    endtask

    // One stimulus cycle plus the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic [1:0] es, input string nm);
        exp_t e;
        @(negedge clk);
        rst   = r;
        req   = rq;
        a_vec = 4'($urandom);
        e.gnt = eg;
        e.s   = es;
        e.nm  = nm;
        q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic exp_y;
        forever begin
            @(posedge clk);
            #2;
            chk("onehot", "gnt_multihot", 4'($countones(gnt) > 1), 4'd0);
            if (q.size() > 0) begin
                e     = q.pop_front();
                exp_y = (e.gnt != 4'd0) ? a_vec[e.s] : 1'b0;
                chk(e.nm, "gnt",       gnt,             e.gnt);
                chk(e.nm, "S",         {2'b00, S},      {2'b00, e.s});
                chk(e.nm, "gnt_valid", {3'b000, gnt_valid}, {3'b000, |e.gnt});
                chk(e.nm, "Y",         {3'b000, Y},     {3'b000, exp_y});
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        a_vec  = 4'b0000;

        // Reset, then a single request. req is ignored during reset.
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, "rst0");
        cyc(1'b1, 4'b1111, 4'b0000, 2'd0, "rst_ignore_req");
        cyc(1'b0, 4'b0010, 4'b0010, 2'd1, "single_grant");
        cyc(1'b0, 4'b0000, 4'b0000, 2'd1, "single_release");

        // All four request; each owns 4 cycles, order 0,1,2,3,0.
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, "rst1");
        for (int i = 0; i < 20; i++) begin
            logic [1:0] own;
            own = 2'((i / 4) % 4);
            cyc(1'b0, 4'b1111, 4'(1 << own), own, "rr_all");
        end

        // Back-to-back hand-off 0 -> 2 with no idle bubble.
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, "rst2");
        cyc(1'b0, 4'b0001, 4'b0001, 2'd0, "own0_a");
        cyc(1'b0, 4'b0001, 4'b0001, 2'd0, "own0_b");
        cyc(1'b0, 4'b0100, 4'b0100, 2'd2, "handoff_0_2");
        cyc(1'b0, 4'b0000, 4'b0000, 2'd2, "idle_after_2");
        // ptr=3 now: search 3,0,1,2 picks 2.
        cyc(1'b0, 4'b0100, 4'b0100, 2'd2, "grant2_ptr3");
        // Owner 2 drops while 0,1 rise: search from 3 -> 0.
        cyc(1'b0, 4'b0011, 4'b0001, 2'd0, "drop_search_s1");
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, "idle_after_0");

        // Sole requester saturation.
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 4'b1000, 4'b1000, 2'd3, "sole_sat");
        cyc(1'b0, 4'b0000, 4'b0000, 2'd3, "sole_release");

        // Mid-grant reset (ptr=0 after release from 3).
        cyc(1'b0, 4'b0100, 4'b0100, 2'd2, "mid_grant2");
        cyc(1'b0, 4'b0110, 4'b0100, 2'd2, "mid_hold2");
        cyc(1'b1, 4'b0110, 4'b0000, 2'd0, "mid_reset");
        cyc(1'b0, 4'b0110, 4'b0010, 2'd1, "post_rst_ptr0");
        cyc(1'b0, 4'b0000, 4'b0000, 2'd1, "post_rst_idle");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
